swc_page_alloc_arbiter: RTL

SWC_PAGE_ALLOC_ARBITER -- requirements
Module: swc_page_alloc_arbiter

---
 rtl/swc_swcore_pkg.sv | 25 ++
 rtl/swc_page_alloc_arbiter_if.sv | 39 +++
 rtl/swc_rr_arbiter.sv | 34 +++
 rtl/swc_page_alloc_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/swc_swcore_pkg.sv
// Shared switch-core definitions: page allocator opcodes, default widths and
// the arbiter FSM state encoding.
package swc_swcore_pkg;

  localparam int c_num_ports       = 7;
  localparam int c_page_addr_width = 10;
  localparam int c_usecount_width  = 4;

  localparam logic [1:0] OP_ALLOC      = 2'b00;
  localparam logic [1:0] OP_FREE       = 2'b01;
  localparam logic [1:0] OP_SET_USECNT = 2'b10;
  localparam logic [1:0] OP_RSVD       = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Width of a port index; a single port still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swc_page_alloc_arbiter_if.sv
// Requester-side and allocator-side signals of the page allocation arbiter.
// Handshake: a port holds req_i (and its operands) high until its one-cycle
// req_ack_o pulse; a command strobe stays high until done_i is sampled high.
interface swc_page_alloc_arbiter_if #(
  parameter int g_num_ports       = 7,
  parameter int g_page_addr_width = 10,
  parameter int g_usecount_width  = 4
);
  logic [g_num_ports-1:0]                   req_i;
  logic [2*g_num_ports-1:0]                 req_op_i;
  logic [g_num_ports*g_page_addr_width-1:0] req_page_i;
  logic [g_num_ports*g_usecount_width-1:0]  req_usecnt_i;
  logic [g_num_ports-1:0]                   req_ack_o;
  logic [g_page_addr_width-1:0]             rsp_page_o;
  logic                                     rsp_nomem_o;

  logic                                     alloc_o;
  logic                                     free_o;
  logic                                     set_usecnt_o;
  logic [g_page_addr_width-1:0]             pg_addr_o;
  logic [g_usecount_width-1:0]              usecnt_o;
  logic                                     done_i;
  logic [g_page_addr_width-1:0]             pg_addr_alloc_i;
  logic                                     nomem_i;

  modport slave (
    input  req_i, req_op_i, req_page_i, req_usecnt_i,
    output req_ack_o, rsp_page_o, rsp_nomem_o,
    output alloc_o, free_o, set_usecnt_o, pg_addr_o, usecnt_o,
    input  done_i, pg_addr_alloc_i, nomem_i
  );

  modport master (
    output req_i, req_op_i, req_page_i, req_usecnt_i,
    input  req_ack_o, rsp_page_o, rsp_nomem_o,
    input  alloc_o, free_o, set_usecnt_o, pg_addr_o, usecnt_o,
    output done_i, pg_addr_alloc_i, nomem_i
  );
endinterface

// File: rtl/swc_rr_arbiter.sv
// Combinational round-robin selector: first requesting port at or above ptr,
// wrapping modulo g_num_ports.
module swc_rr_arbiter
  import swc_swcore_pkg::*;
#(
  parameter int g_num_ports = c_num_ports,
  localparam int IW = idx_width(g_num_ports)
) (
  input  logic [g_num_ports-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [g_num_ports-1:0] grant,
  output logic [IW-1:0]          idx,
  output logic                   any
);

  logic [IW:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(g_num_ports)) pos = pos - (IW+1)'(g_num_ports);
      if (!any && req[pos[IW-1:0]]) begin
        any                = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/swc_page_alloc_arbiter.sv
// Serialises per-port page alloc/free/set_usecnt requests onto a single page
// allocator command port, one operation at a time, in round-robin order.
module swc_page_alloc_arbiter
  import swc_swcore_pkg::*;
#(
  parameter int g_num_ports       = c_num_ports,
  parameter int g_page_addr_width = c_page_addr_width,
  parameter int g_usecount_width  = c_usecount_width
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  swc_page_alloc_arbiter_if.slave  bus,
  output state_t                   state_o
);

  localparam int IW = idx_width(g_num_ports);

  state_t                       state;
  logic [IW-1:0]                rr_ptr;
  logic [IW-1:0]                grant_idx;
  logic [g_num_ports-1:0]       grant_oh;

  logic [g_num_ports-1:0]       arb_grant;
  logic [IW-1:0]                arb_idx;
  logic                         arb_any;

  logic [1:0]                   sel_op;
  logic [g_page_addr_width-1:0] sel_page;
  logic [g_usecount_width-1:0]  sel_uc;

  swc_rr_arbiter #(.g_num_ports(g_num_ports)) u_rr (
    .req   (bus.req_i),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // One-hot grant turns the operand pick into an AND-OR mux.
  always_comb begin
    sel_op   = '0;
    sel_page = '0;
    sel_uc   = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (arb_grant[i]) begin
        sel_op   = sel_op   | bus.req_op_i[2*i +: 2];
        sel_page = sel_page | bus.req_page_i[i*g_page_addr_width +: g_page_addr_width];
        sel_uc   = sel_uc   | bus.req_usecnt_i[i*g_usecount_width +: g_usecount_width];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      grant_idx        <= '0;
      grant_oh         <= '0;
      bus.alloc_o      <= 1'b0;
      bus.free_o       <= 1'b0;
      bus.set_usecnt_o <= 1'b0;
      bus.pg_addr_o    <= '0;
      bus.usecnt_o     <= '0;
      bus.req_ack_o    <= '0;
      bus.rsp_page_o   <= '0;
      bus.rsp_nomem_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            grant_idx     <= arb_idx;
            grant_oh      <= arb_grant;
            bus.pg_addr_o <= sel_page;
            bus.usecnt_o  <= sel_uc;
            case (sel_op)
              OP_ALLOC:         bus.alloc_o      <= 1'b1;
              OP_SET_USECNT:    bus.set_usecnt_o <= 1'b1;
              OP_FREE, OP_RSVD: bus.free_o       <= 1'b1;
            endcase
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.done_i) begin
            bus.alloc_o      <= 1'b0;
            bus.free_o       <= 1'b0;
            bus.set_usecnt_o <= 1'b0;
            bus.pg_addr_o    <= '0;
            bus.usecnt_o     <= '0;
            bus.req_ack_o    <= grant_oh;
            bus.rsp_page_o   <= bus.pg_addr_alloc_i;
            // Out-of-memory only means something for an allocation.
            bus.rsp_nomem_o  <= bus.alloc_o & bus.nomem_i;
            state            <= S_ACK;
          end
        end
        S_ACK: begin
          bus.req_ack_o   <= '0;
          bus.rsp_page_o  <= '0;
          bus.rsp_nomem_o <= 1'b0;
          rr_ptr          <= (grant_idx == IW'(g_num_ports-1)) ? '0 : grant_idx + 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule
